// File: rtl/m_pwm_burst.sv
// Multi-channel PWM burst generator: each channel runs a fixed number of
// PWM periods (or continuously) from a start edge until completion or abort.
module m_pwm_burst #(
  parameter int unsigned CH = 2,
  parameter int unsigned PW = 32,
  parameter int unsigned TW = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [CH-1:0]    i_start,
  input  logic [CH-1:0]    i_stop,
  input  logic [CH*PW-1:0] i_period,
  input  logic [CH*PW-1:0] i_high,
  input  logic [CH*TW-1:0] i_times,
  output logic [CH-1:0]    o_pwm,
  output logic [CH-1:0]    o_busy,
  output logic [CH-1:0]    o_done,
  output logic [CH-1:0]    o_err
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  logic [CH-1:0] r_start;
  logic [CH-1:0] r_arm;
  logic [CH-1:0] w_start_edge;

  // r_arm blocks a start that was already high when reset released until it drops
  assign w_start_edge = i_start & ~r_start & r_arm;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_start <= '0;
      r_arm   <= ~i_start;
    end else begin
      r_start <= i_start;
      r_arm   <= r_arm | ~i_start;
    end
  end

  for (genvar n = 0; n < CH; n++) begin : g_ch
    state_t        r_state;
    logic [PW-1:0] r_period;
    logic [PW-1:0] r_high;
    logic [PW-1:0] r_pcnt;
    logic [TW-1:0] r_times;
    logic [TW-1:0] r_tcnt;
    logic          r_pwm;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic [PW-1:0] w_period_in;
    logic [PW-1:0] w_high_in;
    logic [TW-1:0] w_times_in;
    logic          w_wrap;
    logic          w_last;

    assign w_period_in = i_period[n*PW +: PW];
    assign w_high_in   = i_high[n*PW +: PW];
    assign w_times_in  = i_times[n*TW +: TW];

    // Period boundary, and final period of a counted burst
    assign w_wrap = (r_pcnt == r_period - PW'(1));
    assign w_last = w_wrap && (r_times != '0) && (r_tcnt == r_times - TW'(1));

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        r_state  <= S_IDLE;
        r_period <= '0;
        r_high   <= '0;
        r_times  <= '0;
        r_pcnt   <= '0;
        r_tcnt   <= '0;
        r_pwm    <= 1'b0;
        r_busy   <= 1'b0;
        r_done   <= 1'b0;
        r_err    <= 1'b0;
      end else begin
        r_done <= 1'b0;
        r_err  <= 1'b0;
        case (r_state)
          S_IDLE: begin
            r_pwm <= 1'b0;
            if (w_start_edge[n] && !i_stop[n]) begin
              if (w_period_in < PW'(2)) begin
                r_err <= 1'b1;
              end else begin
                r_state  <= S_RUN;
                r_period <= w_period_in;
                r_high   <= w_high_in;
                r_times  <= w_times_in;
                r_pcnt   <= '0;
                r_tcnt   <= '0;
                r_busy   <= 1'b1;
              end
            end
          end
          S_RUN: begin
            if (i_stop[n]) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_pwm   <= 1'b0;
            end else begin
              r_pwm <= (r_pcnt < r_high);
              if (w_wrap) begin
                r_pcnt <= '0;
                if (w_last) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                end else if (r_tcnt != '1) begin
                  r_tcnt <= r_tcnt + TW'(1);
                end
              end else begin
                r_pcnt <= r_pcnt + PW'(1);
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end

    assign o_pwm[n]  = r_pwm;
    assign o_busy[n] = r_busy;
    assign o_done[n] = r_done;
    assign o_err[n]  = r_err;
  end

endmodule

// File: tb/tb_m_pwm_burst.sv
// Bench for m_pwm_burst: directed vector table, directed burst sequences and a
// randomized run, all checked against a cycle-count reference model.
module tb_m_pwm_burst;

  localparam int unsigned CH = 2;
  localparam int unsigned PW = 32;
  localparam int unsigned TW = 16;

  logic             i_clk;
  logic             i_rst_n;
  logic [CH-1:0]    i_start;
  logic [CH-1:0]    i_stop;
  logic [CH*PW-1:0] i_period;
  logic [CH*PW-1:0] i_high;
  logic [CH*TW-1:0] i_times;
  logic [CH-1:0]    o_pwm;
  logic [CH-1:0]    o_busy;
  logic [CH-1:0]    o_done;
  logic [CH-1:0]    o_err;

  m_pwm_burst #(.CH(CH), .PW(PW), .TW(TW)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_start  (i_start),
    .i_stop   (i_stop),
    .i_period (i_period),
    .i_high   (i_high),
    .i_times  (i_times),
    .o_pwm    (o_pwm),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_err    (o_err)
  );

  initial i_clk = 1'b0;
  always #10 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a burst is "k cycles into the run"; output is (k mod P) < H,
  // and a counted burst ends after P*T cycles.
  bit              m_act  [CH];
  bit              m_prev [CH];
  bit              m_arm  [CH];
  longint unsigned m_k    [CH];
  longint unsigned m_p    [CH];
  longint unsigned m_h    [CH];
  longint unsigned m_t    [CH];
  logic [CH-1:0]   e_pwm, e_busy, e_done, e_err;

  int cyc;
  int c_pwm  [CH];
  int c_busy [CH];
  int c_done [CH];
  int c_err  [CH];
  int t_done [CH];

  typedef struct {
    logic          st;
    logic          sp;
    logic [PW-1:0] per;
    logic [PW-1:0] hi;
    logic [TW-1:0] tm;
    logic          pwm;
    logic          busy;
    logic          done;
    logic          err;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%b want=%b", nm, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_step();
    longint unsigned p;
    bit s, sp, ev;
    for (int n = 0; n < CH; n++) begin
      p  = longint'(i_period[n*PW +: PW]);
      s  = i_start[n];
      sp = i_stop[n];
      e_done[n] = 1'b0;
      e_err[n]  = 1'b0;
      if (!i_rst_n) begin
        m_act[n]  = 1'b0;
        m_prev[n] = 1'b0;
        m_arm[n]  = !s;
        e_pwm[n]  = 1'b0;
        e_busy[n] = 1'b0;
      end else begin
        ev = s && !m_prev[n] && m_arm[n];
        m_prev[n] = s;
        if (!s) m_arm[n] = 1'b1;
        if (m_act[n]) begin
          if (sp) begin
            m_act[n]  = 1'b0;
            e_pwm[n]  = 1'b0;
            e_busy[n] = 1'b0;
          end else begin
            e_pwm[n] = ((m_k[n] % m_p[n]) < m_h[n]);
            m_k[n]++;
            if (m_t[n] != 0 && m_k[n] == m_p[n] * m_t[n]) begin
              m_act[n]  = 1'b0;
              e_busy[n] = 1'b0;
              e_done[n] = 1'b1;
            end else begin
              e_busy[n] = 1'b1;
            end
          end
        end else begin
          e_pwm[n]  = 1'b0;
          e_busy[n] = 1'b0;
          if (ev && !sp) begin
            if (p < 2) begin
              e_err[n] = 1'b1;
            end else begin
              m_act[n]  = 1'b1;
              m_k[n]    = 0;
              m_p[n]    = p;
              m_h[n]    = longint'(i_high[n*PW +: PW]);
              m_t[n]    = longint'(i_times[n*TW +: TW]);
              e_busy[n] = 1'b1;
            end
          end
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge i_clk);
    #1;
    cyc++;
    chk("pwm", o_pwm, e_pwm);
    chk("busy", o_busy, e_busy);
    chk("done", o_done, e_done);
    chk("err", o_err, e_err);
    for (int n = 0; n < CH; n++) begin
      if (o_pwm[n] === 1'b1)  c_pwm[n]++;
      if (o_busy[n] === 1'b1) c_busy[n]++;
      if (o_done[n] === 1'b1) begin c_done[n]++; t_done[n] = cyc; end
      if (o_err[n] === 1'b1)  c_err[n]++;
    end
  endtask

  task automatic clr();
    cyc = 0;
    for (int n = 0; n < CH; n++) begin
      c_pwm[n] = 0; c_busy[n] = 0; c_done[n] = 0; c_err[n] = 0; t_done[n] = -1;
    end
  endtask

  task automatic set_ch(input int n, input logic [PW-1:0] p, input logic [PW-1:0] h,
                        input logic [TW-1:0] t);
    i_period[n*PW +: PW] = p;
    i_high[n*PW +: PW]   = h;
    i_times[n*TW +: TW]  = t;
  endtask

  task automatic do_reset();
    i_start  = '0;
    i_stop   = '0;
    i_period = '0;
    i_high   = '0;
    i_times  = '0;
    i_rst_n  = 1'b0;
    tick();
    chk("rst_state", o_busy | o_pwm | o_done | o_err, '0);
    i_rst_n = 1'b1;
  endtask

  initial begin
    // ch0 vectors from idle: rejected start, a 3-cycle burst, then start+stop together
    tbl[0] = '{1'b0, 1'b0, PW'(3), PW'(1), TW'(1), 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, PW'(1), PW'(1), TW'(1), 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b0, PW'(1), PW'(1), TW'(1), 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, PW'(3), PW'(1), TW'(1), 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, PW'(7), PW'(5), TW'(4), 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, PW'(7), PW'(5), TW'(4), 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, PW'(7), PW'(5), TW'(4), 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b0, PW'(3), PW'(1), TW'(1), 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 1'b1, PW'(3), PW'(1), TW'(1), 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{1'b0, 1'b0, PW'(3), PW'(1), TW'(1), 1'b0, 1'b0, 1'b0, 1'b0};

    clr();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      i_start[0] = tbl[i].st;
      i_stop[0]  = tbl[i].sp;
      set_ch(0, tbl[i].per, tbl[i].hi, tbl[i].tm);
      tick();
      chk_int($sformatf("vec%0d_pwm", i),  int'(o_pwm[0]),  int'(tbl[i].pwm));
      chk_int($sformatf("vec%0d_busy", i), int'(o_busy[0]), int'(tbl[i].busy));
      chk_int($sformatf("vec%0d_done", i), int'(o_done[0]), int'(tbl[i].done));
      chk_int($sformatf("vec%0d_err", i),  int'(o_err[0]),  int'(tbl[i].err));
    end

    // Counted burst: 10/4 x3
    do_reset();
    clr();
    set_ch(0, PW'(10), PW'(4), TW'(3));
    i_start[0] = 1'b1;
    tick();
    i_start[0] = 1'b0;
    repeat (40) tick();
    chk_int("b31_busy", c_busy[0], 30);
    chk_int("b31_pwm", c_pwm[0], 12);
    chk_int("b31_done", c_done[0], 1);

    // Continuous 5/2 for 100 cycles, then stop
    do_reset();
    clr();
    set_ch(0, PW'(5), PW'(2), TW'(0));
    i_start[0] = 1'b1;
    tick();
    i_start[0] = 1'b0;
    repeat (100) tick();
    chk_int("b32_pwm", c_pwm[0], 40);
    chk_int("b32_busy", c_busy[0], 101);
    i_stop[0] = 1'b1;
    tick();
    chk_int("b32_stop_busy", int'(o_busy[0]), 0);
    chk_int("b32_stop_pwm", int'(o_pwm[0]), 0);
    i_stop[0] = 1'b0;
    repeat (3) tick();
    chk_int("b32_no_done", c_done[0], 0);

    // Rejected start, high=0 and high=period extremes
    do_reset();
    clr();
    set_ch(0, PW'(1), PW'(0), TW'(1));
    i_start[0] = 1'b1;
    tick();
    i_start[0] = 1'b0;
    repeat (3) tick();
    chk_int("b33_err", c_err[0], 1);
    chk_int("b33_err_busy", c_busy[0], 0);
    clr();
    set_ch(0, PW'(8), PW'(0), TW'(1));
    i_start[0] = 1'b1;
    tick();
    i_start[0] = 1'b0;
    repeat (10) tick();
    chk_int("b33_low_pwm", c_pwm[0], 0);
    chk_int("b33_low_busy", c_busy[0], 8);
    clr();
    set_ch(0, PW'(8), PW'(8), TW'(1));
    i_start[0] = 1'b1;
    tick();
    i_start[0] = 1'b0;
    repeat (10) tick();
    chk_int("b33_high_pwm", c_pwm[0], 8);
    chk_int("b33_high_done", c_done[0], 1);

    // Two channels started together
    do_reset();
    clr();
    set_ch(0, PW'(6), PW'(3), TW'(2));
    set_ch(1, PW'(9), PW'(4), TW'(2));
    i_start = '1;
    tick();
    i_start = '0;
    repeat (24) tick();
    chk_int("b34_done0_at", t_done[0], 13);
    chk_int("b34_done1_at", t_done[1], 19);
    chk_int("b34_pwm0", c_pwm[0], 6);
    chk_int("b34_pwm1", c_pwm[1], 8);

    // Reset mid-burst with start held high
    do_reset();
    clr();
    set_ch(0, PW'(10), PW'(4), TW'(5));
    i_start[0] = 1'b1;
    tick();
    repeat (7) tick();
    i_rst_n = 1'b0;
    tick();
    chk("b35_rst_out", o_pwm | o_busy | o_done | o_err, '0);
    i_rst_n = 1'b1;
    clr();
    repeat (5) tick();
    chk_int("b35_no_restart", c_busy[0], 0);
    chk_int("b35_no_done", c_done[0], 0);
    i_start[0] = 1'b0;
    tick();
    i_start[0] = 1'b1;
    tick();
    chk_int("b35_restart", int'(o_busy[0]), 1);
    i_start[0] = 1'b0;
    i_stop[0]  = 1'b1;
    tick();
    i_stop[0]  = 1'b0;

    // Inputs changing mid-burst do not disturb it
    do_reset();
    clr();
    set_ch(0, PW'(10), PW'(4), TW'(2));
    i_start[0] = 1'b1;
    tick();
    i_start[0] = 1'b0;
    set_ch(0, PW'(3), PW'(1), TW'(7));
    repeat (4) tick();
    i_start[0] = 1'b1;
    repeat (3) tick();
    i_start[0] = 1'b0;
    repeat (20) tick();
    chk_int("b36_pwm", c_pwm[0], 8);
    chk_int("b36_busy", c_busy[0], 20);
    chk_int("b36_done", c_done[0], 1);

    // Randomized run against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      i_rst_n = ($urandom_range(0, 599) != 0);
      for (int n = 0; n < CH; n++) begin
        if ($urandom_range(0, 3) == 0) i_start[n] = ~i_start[n];
        i_stop[n] = ($urandom_range(0, 31) == 0);
        if ($urandom_range(0, 5) == 0) begin
          case ($urandom_range(0, 9))
            0:       i_period[n*PW +: PW] = PW'($urandom_range(0, 1));
            1:       i_period[n*PW +: PW] = {PW{1'b1}} - PW'($urandom_range(0, 15));
            default: i_period[n*PW +: PW] = PW'($urandom_range(2, 12));
          endcase
          if ($urandom_range(0, 7) == 0) i_high[n*PW +: PW] = {PW{1'b1}};
          else                           i_high[n*PW +: PW] = PW'($urandom_range(0, 14));
          i_times[n*TW +: TW] = TW'($urandom_range(0, 3));
        end
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
